// File: rtl/bfp_compress_blk.sv
// Block-floating-point compressor: ping-pong block buffer, per-channel exponent, rounded/saturated mantissas.
// Optional saturation counter enabled by defining BFP_SAT_CNT_EN (adds i_cnt_clr / o_sat_cnt).
module bfp_compress_blk #(
  parameter int CH   = 1,
  parameter int IW   = 16,
  parameter int MW   = 9,
  parameter int BLK  = 12,
  parameter int EXPW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic                 i_sop,
  input  logic                 i_eop,
  input  logic [CH*2*IW-1:0]   i_din,
  input  logic [6:0]           i_slot_idx,
  input  logic [3:0]           i_symb_idx,
  input  logic [8:0]           i_prb_idx,
`ifdef BFP_SAT_CNT_EN
  input  logic                 i_cnt_clr,
  output logic [15:0]          o_sat_cnt,
`endif
  output logic                 o_vld,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic [CH*2*MW-1:0]   o_dout,
  output logic [CH*EXPW-1:0]   o_exp,
  output logic [6:0]           o_slot_idx,
  output logic [3:0]           o_symb_idx,
  output logic [8:0]           o_prb_idx,
  output logic                 o_err
);

  localparam int AW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic signed [IW:0] MAXV = (IW+1)'(2**(MW-1) - 1);
  localparam logic signed [IW:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, FILL, DISCARD} state_t;

  state_t                 state;
  logic [AW-1:0]          wr_cnt, pos, rd_cnt, rd_addr;
  logic                   wr_bank, drain_bank, accept, last, close;
  logic [CH*(IW-1)-1:0]   acc, acc_nxt, blk_or;
  logic [19:0]            side_in, side_fill, side_pend, side_cur;
  logic [CH*2*IW-1:0]     ram [2][BLK];
  logic [CH*2*IW-1:0]     rd_data;
  logic                   rd_act, rd_vld, rd_first, rd_last;
  logic [CH*EXPW-1:0]     exp_cur;
  logic [CH*2*MW-1:0]     dout_nxt;
`ifdef BFP_SAT_CNT_EN
  logic [15:0]            sat_n;
`endif

  function automatic logic [IW-2:0] mag(input logic [IW-1:0] x);
    return x[IW-1] ? ~x[IW-2:0] : x[IW-2:0];
  endfunction

  function automatic logic [EXPW-1:0] calc_exp(input logic [IW-2:0] m);
    int e;
    e = 0;
    for (int i = 0; i < IW-1; i++)
      if (m[i] && (i + 2 - MW) > 0) e = i + 2 - MW;
    return EXPW'(e);
  endfunction

  function automatic logic signed [IW:0] rnd(input logic [IW-1:0] x, input logic [EXPW-1:0] e);
    logic signed [IW:0] xs;
    xs = $signed({x[IW-1], x});
    if (e == '0) return xs;
    return $signed(xs + ((IW+1)'(1) <<< (e - EXPW'(1)))) >>> e;
  endfunction

  assign side_in = {i_slot_idx, i_symb_idx, i_prb_idx};

  always_comb begin
    pos     = i_sop ? '0 : wr_cnt;
    accept  = i_vld && (i_sop || state == FILL);
    last    = (pos == AW'(BLK-1));
    acc_nxt = i_sop ? '0 : acc;
    for (int c = 0; c < CH; c++)
      acc_nxt[c*(IW-1) +: IW-1] = acc_nxt[c*(IW-1) +: IW-1]
                                  | mag(i_din[c*2*IW +: IW]) | mag(i_din[c*2*IW+IW +: IW]);
  end

  // Framing FSM: a block closes on the BLK-th accepted sample; eop only decides whether that is clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      drain_bank <= 1'b0;
      acc        <= '0;
      blk_or     <= '0;
      side_fill  <= '0;
      side_pend  <= '0;
      close      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      close <= 1'b0;
      o_err <= 1'b0;
      if (accept) begin
        acc <= acc_nxt;
        if (i_sop) side_fill <= side_in;
        if (last) begin
          close      <= 1'b1;
          blk_or     <= acc_nxt;
          side_pend  <= i_sop ? side_in : side_fill;
          drain_bank <= wr_bank;
          wr_bank    <= ~wr_bank;
          wr_cnt     <= '0;
          state      <= i_eop ? IDLE : DISCARD;
          o_err      <= (i_sop && state == FILL) || !i_eop;
        end else if (i_eop) begin
          wr_cnt <= '0;
          state  <= IDLE;
          o_err  <= 1'b1;
        end else begin
          wr_cnt <= pos + AW'(1);
          state  <= FILL;
          o_err  <= i_sop && state == FILL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) ram[wr_bank][pos] <= i_din;
  end

  assign rd_addr = close ? '0 : rd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_act   <= 1'b0;
      rd_cnt   <= '0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      exp_cur  <= '0;
      side_cur <= '0;
    end else begin
      rd_vld   <= close || rd_act;
      rd_first <= close;
      rd_last  <= (close || rd_act) && (rd_addr == AW'(BLK-1));
      if (close || rd_act) rd_data <= ram[drain_bank][rd_addr];
      if (close) begin
        for (int c = 0; c < CH; c++)
          exp_cur[c*EXPW +: EXPW] <= calc_exp(blk_or[c*(IW-1) +: IW-1]);
        side_cur <= side_pend;
        rd_cnt   <= AW'(1);
        rd_act   <= (BLK > 1);
      end else if (rd_act) begin
        rd_act <= (rd_cnt != AW'(BLK-1));
        rd_cnt <= rd_cnt + AW'(1);
      end
    end
  end

  always_comb begin
    logic signed [IW:0] r;
    dout_nxt = '0;
`ifdef BFP_SAT_CNT_EN
    sat_n = '0;
`endif
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 2; k++) begin
        r = rnd(rd_data[c*2*IW + k*IW +: IW], exp_cur[c*EXPW +: EXPW]);
        if (r > MAXV || r < MINV) begin
          dout_nxt[c*2*MW + k*MW +: MW] = (r > MAXV) ? MAXV[MW-1:0] : MINV[MW-1:0];
`ifdef BFP_SAT_CNT_EN
          sat_n = sat_n + 16'd1;
`endif
        end else begin
          dout_nxt[c*2*MW + k*MW +: MW] = r[MW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld      <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_dout     <= '0;
      o_exp      <= '0;
      o_slot_idx <= '0;
      o_symb_idx <= '0;
      o_prb_idx  <= '0;
    end else begin
      o_vld <= rd_vld;
      o_sop <= rd_vld && rd_first;
      o_eop <= rd_vld && rd_last;
      if (rd_vld) o_dout <= dout_nxt;
      if (rd_vld && rd_first) begin
        o_exp <= exp_cur;
        {o_slot_idx, o_symb_idx, o_prb_idx} <= side_cur;
      end
    end
  end

`ifdef BFP_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || i_cnt_clr)
      o_sat_cnt <= '0;
    else if (rd_vld)
      o_sat_cnt <= (17'(o_sat_cnt) + 17'(sat_n) > 17'h0FFFF) ? 16'hFFFF : o_sat_cnt + sat_n;
  end
`endif

endmodule
